// File: rtl/mips_pkg.sv
// Shared MIPS decode encodings (opcode, funct, ALU control) used by ID and EX stages.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_NOR = 6'h27,
    FN_SLT = 6'h2A
  } funct_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_write;
    logic      alu_src;
    logic      reg_dst;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_write:  1'b0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    alu_ctrl:   ALU_AND
  };

  function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID-stage bus: IF/ID inputs, writeback and hazard inputs, ID/EX and control outputs.
interface id_stage_if;
  logic [31:0] Instr_ID;
  logic [31:0] PCPlus4_ID;

  logic        RegWrite_WB;
  logic [4:0]  WriteReg_WB;
  logic [31:0] Result_WB;

  logic        RegWrite_Ex;
  logic        MemtoReg_Ex;
  logic [4:0]  WriteReg_Ex;
  logic        RegWrite_Mem;
  logic [4:0]  WriteReg_Mem;

  logic [31:0] dataone_ID;
  logic [31:0] WriteData_ID;
  logic [31:0] extendedimm_ID;
  logic        RegWrite_ID;
  logic        MemtoReg_ID;
  logic        MemWrite_ID;
  logic        ALUSrc_ID;
  logic        RegDst_ID;
  logic [3:0]  ALUControl_ID;

  logic        Stall_ID;
  logic        PCSrc_ID;
  logic [31:0] PCBranch_ID;
  logic        Flush_IF;
  logic        Illegal_ID;

  modport master (
    output Instr_ID, PCPlus4_ID,
    output RegWrite_WB, WriteReg_WB, Result_WB,
    output RegWrite_Ex, MemtoReg_Ex, WriteReg_Ex, RegWrite_Mem, WriteReg_Mem,
    input  dataone_ID, WriteData_ID, extendedimm_ID,
    input  RegWrite_ID, MemtoReg_ID, MemWrite_ID, ALUSrc_ID, RegDst_ID, ALUControl_ID,
    input  Stall_ID, PCSrc_ID, PCBranch_ID, Flush_IF, Illegal_ID
  );

  modport slave (
    input  Instr_ID, PCPlus4_ID,
    input  RegWrite_WB, WriteReg_WB, Result_WB,
    input  RegWrite_Ex, MemtoReg_Ex, WriteReg_Ex, RegWrite_Mem, WriteReg_Mem,
    output dataone_ID, WriteData_ID, extendedimm_ID,
    output RegWrite_ID, MemtoReg_ID, MemWrite_ID, ALUSrc_ID, RegDst_ID, ALUControl_ID,
    output Stall_ID, PCSrc_ID, PCBranch_ID, Flush_IF, Illegal_ID
  );
endinterface

// File: rtl/regfile.sv
// 32x32 register file: two async read ports with write-through bypass, one write port, async clear.
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_en;
  logic        byp_en;

  always_comb begin
    wr_en  = we && (wa != '0);
    byp_en = wr_en && rst_n;
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // Bypass is masked during reset so a pending writeback never leaks out.
  always_comb begin
    rd1 = regs_q[ra1];
    if (ra1 == '0)                  rd1 = '0;
    else if (byp_en && (wa == ra1)) rd1 = wd;

    rd2 = regs_q[ra2];
    if (ra2 == '0)                  rd2 = '0;
    else if (byp_en && (wa == ra2)) rd2 = wd;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, register read, hazard stall and early branch resolution.
module id_stage
  import mips_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  id_stage_if.slave bus
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] ext_imm;
  ctrl_t       ctrl;
  logic        illegal;
  logic        uses_rt;
  logic        is_beq;
  logic        is_bne;
  logic        load_use;
  logic        branch_haz;
  logic        stall;
  logic        taken;

  assign opcode = bus.Instr_ID[31:26];
  assign rs     = bus.Instr_ID[25:21];
  assign rt     = bus.Instr_ID[20:16];
  assign funct  = bus.Instr_ID[5:0];

  regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .we    (bus.RegWrite_WB),
    .wa    (bus.WriteReg_WB),
    .wd    (bus.Result_WB)
  );

  always_comb begin
    ctrl    = CTRL_NONE;
    illegal = 1'b0;
    uses_rt = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt        = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl.alu_ctrl = ALU_AND;
          FN_OR:   ctrl.alu_ctrl = ALU_OR;
          FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
          FN_NOR:  ctrl.alu_ctrl = ALU_NOR;
          default: illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        uses_rt        = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        uses_rt       = 1'b1;
        is_beq        = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_BNE: begin
        uses_rt       = 1'b1;
        is_bne        = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) ctrl = CTRL_NONE;
  end

  always_comb begin
    ext_imm  = sign_extend16(bus.Instr_ID[15:0]);
    load_use = bus.MemtoReg_Ex && (bus.WriteReg_Ex != '0) &&
               ((bus.WriteReg_Ex == rs) || (uses_rt && (bus.WriteReg_Ex == rt)));
    // Branches compare in ID, so any in-flight producer of rs/rt must drain first.
    branch_haz = (is_beq || is_bne) &&
                 ((bus.RegWrite_Ex && (bus.WriteReg_Ex != '0) &&
                   ((bus.WriteReg_Ex == rs) || (bus.WriteReg_Ex == rt))) ||
                  (bus.RegWrite_Mem && (bus.WriteReg_Mem != '0) &&
                   ((bus.WriteReg_Mem == rs) || (bus.WriteReg_Mem == rt))));
    stall = load_use || branch_haz;
    taken = !stall && ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)));
  end

  always_comb begin
    bus.dataone_ID     = rs_val;
    bus.WriteData_ID   = rt_val;
    bus.extendedimm_ID = ext_imm;
    bus.RegWrite_ID    = ctrl.reg_write  && !stall;
    bus.MemtoReg_ID    = ctrl.mem_to_reg && !stall;
    bus.MemWrite_ID    = ctrl.mem_write  && !stall;
    bus.ALUSrc_ID      = ctrl.alu_src;
    bus.RegDst_ID      = ctrl.reg_dst;
    bus.ALUControl_ID  = ctrl.alu_ctrl;
    bus.Stall_ID       = stall;
    bus.PCSrc_ID       = taken;
    bus.Flush_IF       = taken;
    bus.PCBranch_ID    = bus.PCPlus4_ID + {ext_imm[29:0], 2'b00};
    bus.Illegal_ID     = illegal;
  end

endmodule
